// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq
//   Iterative AES InvSubBytes engine. A 128-bit state is captured through a
//   valid/ready handshake. BYTES_PER_CYCLE bytes are then pushed through the
//   Rijndael inverse S-box on each BUSY cycle, lowest byte index first. The
//   finished state is held in a register until downstream takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   instate    state to substitute; byte k = instate[8k+7:8k]
//   in_valid   instate is valid
//   in_ready   a new state can be accepted (IDLE only)
//   outstate   registered substituted state
//   out_valid  outstate is valid (DONE)
//   out_ready  downstream accepts outstate
//   busy       substitution in progress (BUSY)
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] instate,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] outstate,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int NCHUNK  = 16 / BYTES_PER_CYCLE;
  localparam int CW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Rijndael inverse S-box, indexed by the full byte value.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [127:0]    work_reg;
  logic [127:0]    work_next;
  logic [127:0]    outstate_reg;
  logic [CHUNK_W-1:0] chunk_in;
  logic [CHUNK_W-1:0] chunk_out;

  // Only BYTES_PER_CYCLE S-box lookups exist; the counter steers which
  // slice of the working register passes through them.
  assign chunk_in = work_reg[int'(cnt_reg) * CHUNK_W +: CHUNK_W];

  generate
    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
      assign chunk_out[gi*8 +: 8] = INV_SBOX[chunk_in[gi*8 +: 8]];
    end
  endgenerate

  always_comb begin
    work_next = work_reg;
    work_next[int'(cnt_reg) * CHUNK_W +: CHUNK_W] = chunk_out;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (cnt_reg == LAST_CHUNK) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register
  always_comb begin
    in_ready  = (state_reg == IDLE);
    busy      = (state_reg == BUSY);
    out_valid = (state_reg == DONE);
  end

  assign outstate = outstate_reg;

  // Datapath: capture, chunked substitution, result load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg     <= '0;
      cnt_reg      <= '0;
      outstate_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg <= instate;
            cnt_reg  <= '0;
          end
        end
        BUSY: begin
          work_reg <= work_next;
          if (cnt_reg == LAST_CHUNK) begin
            // Counter is cleared here rather than allowed to wrap.
            cnt_reg      <= '0;
            outstate_reg <= work_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;

  localparam int BPC    = 4;
  localparam int NCHUNK = 16 / BPC;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] instate = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [127:0] outstate;
  logic         out_valid;
  logic         busy;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .instate   (instate),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outstate  (outstate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Forward S-box derived from GF(2^8) inversion + affine map; the inverse
  // table is then obtained by inverting that permutation.
  logic [7:0] sbox    [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, x8, y8;
    for (int x = 0; x < 256; x++) begin
      x8 = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        y8 = y[7:0];
        if (x != 0 && gmul(x8, y8) == 8'h01) inv = y8;
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      inv_tab[s] = x8;
    end
  endtask

  function automatic logic [127:0] inv_state(input logic [127:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[blk[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model: a block is accepted when idle, spends NCHUNK cycles
  // in progress, then waits for out_ready holding InvS of every byte.
  logic         m_idle = 1'b1;
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [127:0] m_blk  = '0;
  logic [127:0] m_out  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_left <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_blk  <= instate;
        m_left <= NCHUNK;
        m_idle <= 1'b0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_out  <= inv_state(m_blk);
      end
    end else if (m_done && out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  int           log_cyc [$];
  logic [127:0] log_dat [$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_in_ready", in_ready, m_idle);
    chk("cyc_busy", busy, (m_left != 0));
    chk("cyc_out_valid", out_valid, m_done);
    chk("cyc_outstate", outstate, m_out);
    if (out_valid && out_ready) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(outstate);
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sends one block, waits for the result, hands it off.
  task automatic run_block(input logic [127:0] blk, output logic [127:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("idle_before_send", in_ready, 1'b1);
    instate = blk; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ready_drop_after_accept", in_ready, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency", n, NCHUNK);
    res = outstate;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop_after_handoff", out_valid, 1'b0);
    $display("block in=%h out=%h latency=%0d", blk, res, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] res, blk, exp_hold;
    logic [127:0] b2b [3];
    logic [7:0]   xb;
    logic         rdy;
    int           idx, n;

    build_tables();
    // Pin the derived model to known table entries.
    chk("model_inv_00", inv_tab[8'h00], 8'h52);
    chk("model_inv_63", inv_tab[8'h63], 8'h00);
    chk("model_inv_7c", inv_tab[8'h7c], 8'h01);
    chk("model_inv_16", inv_tab[8'h16], 8'hff);
    chk("model_inv_52", inv_tab[8'h52], 8'h48);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_outstate", outstate, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero state
    run_block(128'h0, res);
    chk("zero_block", res, {16{8'h52}});

    // Directed low bytes
    run_block({{11{8'h63}}, 8'h93, 8'he1, 8'h4d, 8'h89, 8'h76}, res);
    chk("directed_block", res, {{11{8'h00}}, 8'h22, 8'he0, 8'h65, 8'hf2, 8'h0f});

    // Round trip on bytes 0 and 15
    for (int x = 0; x < 256; x++) begin
      xb = x[7:0];
      blk = rand128();
      blk[7:0] = sbox[x];
      blk[127:120] = sbox[x];
      run_block(blk, res);
      chk("roundtrip_byte0", res[7:0], xb);
      chk("roundtrip_byte15", res[127:120], xb);
    end

    // Backpressure in DONE
    blk = rand128();
    exp_hold = inv_state(blk);
    instate = blk; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, NCHUNK);
    for (int i = 0; i < 10; i++) begin
      instate = rand128();
      in_valid = $urandom_range(0, 1);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_outstate", outstate, exp_hold);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_busy", busy, 1'b0);
    $display("block in=%h out=%h backpressure=10", blk, exp_hold);

    // Asynchronous reset inside the second busy cycle
    instate = rand128(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < ((NCHUNK >= 2) ? 1 : 0); i++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_outstate", outstate, 128'h0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    blk = rand128();
    run_block(blk, res);
    chk("after_reset_block", res, inv_state(blk));

    // Back-to-back with both handshakes held high
    log_cyc.delete();
    log_dat.delete();
    for (int i = 0; i < 3; i++) b2b[i] = rand128();
    idx = 0; n = 0;
    instate = b2b[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (idx < 3 && n < 200) begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
      if (rdy) begin
        idx++;
        if (idx < 3) instate = b2b[idx];
        else in_valid = 1'b0;
      end
    end
    repeat (NCHUNK + 4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_count", log_dat.size(), 3);
    for (int i = 0; i < 3 && i < log_dat.size(); i++) begin
      chk("b2b_data", log_dat[i], inv_state(b2b[i]));
      $display("block in=%h out=%h at cycle %0d", b2b[i], log_dat[i], log_cyc[i]);
    end
    for (int i = 1; i < 3 && i < log_cyc.size(); i++)
      chk("b2b_spacing", log_cyc[i] - log_cyc[i-1], NCHUNK + 2);

    // Random traffic, checked by the per-cycle comparison
    for (int i = 0; i < 400; i++) begin
      instate   = rand128();
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (NCHUNK + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
